frogger_game_ctrl: RTL and testbench

Game-sequencing controller for the Frogger design. It sits between the debounced switches, the frog-movement datapath and the sprite/score display. It decides when the frog may move, when it is respawned, and how score, lives and level evolve. Frame pacing comes from a one-cycle frame tick derived from VGA vertical sync.

---
 rtl/frogger_game_ctrl_pkg.sv | 37 +++
 rtl/frogger_game_ctrl_if.sv | 38 +++
 rtl/frogger_game_ctrl_frame_counter.sv | 56 +++++
 rtl/frogger_game_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/frogger_game_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// frogger_game_ctrl_pkg
// Shared constants for the Frogger game-sequencing controller: state
// encodings, datapath widths, the score ceiling and a saturating-increment
// helper used for the score register.
// ----------------------------------------------------------------------------
package frogger_game_ctrl_pkg;

    localparam int STATE_W     = 3;
    localparam int SCORE_W     = 7;
    localparam int LIVES_W     = 2;
    localparam int LEVEL_W     = 3;
    localparam int TIME_W      = 11;
    localparam int FRAME_CNT_W = 7;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    // Score + 1, holding at SCORE_MAX.
    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (v >= SCORE_MAX) begin
            r = SCORE_MAX;
        end else begin
            r = v + 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// ----------------------------------------------------------------------------
// frogger_game_ctrl_if
// Bundles the controller's game-facing signals.
//   master : environment side (switch/collision logic) drives the i_* inputs
//            and observes the o_* status outputs.
//   slave  : the controller itself.
// Signals: i_Frame_Tick, i_Any_Switch, i_Collision, i_Frog_At_Goal (inputs);
//          o_State, o_Move_En, o_Frog_Respawn, o_Score, o_Lives, o_Level,
//          o_Time_Left (outputs).
// ----------------------------------------------------------------------------
interface frogger_game_ctrl_if;
    import frogger_game_ctrl_pkg::*;

    logic                 i_Frame_Tick;
    logic                 i_Any_Switch;
    logic                 i_Collision;
    logic                 i_Frog_At_Goal;
    logic [STATE_W-1:0]   o_State;
    logic                 o_Move_En;
    logic                 o_Frog_Respawn;
    logic [SCORE_W-1:0]   o_Score;
    logic [LIVES_W-1:0]   o_Lives;
    logic [LEVEL_W-1:0]   o_Level;
    logic [TIME_W-1:0]    o_Time_Left;

    modport master (
        output i_Frame_Tick, i_Any_Switch, i_Collision, i_Frog_At_Goal,
        input  o_State, o_Move_En, o_Frog_Respawn, o_Score, o_Lives,
               o_Level, o_Time_Left
    );

    modport slave (
        input  i_Frame_Tick, i_Any_Switch, i_Collision, i_Frog_At_Goal,
        output o_State, o_Move_En, o_Frog_Respawn, o_Score, o_Lives,
               o_Level, o_Time_Left
    );

endinterface

// File: rtl/frogger_game_ctrl_frame_counter.sv
// ----------------------------------------------------------------------------
// frogger_game_ctrl_frame_counter
// Clearable counter of frame-tick pulses with a terminal-count strobe.
// Ports:
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   clear_i  : synchronous clear (wins over counting)
//   tick_i   : frame tick, already qualified by the owning state
//   done_o   : high in the cycle the TERMINAL-th tick arrives
// done_o is a same-cycle strobe so the controller can change state on the
// very edge that samples the terminal tick; the controller registers the
// resulting state, so nothing combinational reaches a top-level output.
// ----------------------------------------------------------------------------
module frogger_game_ctrl_frame_counter
    import frogger_game_ctrl_pkg::*;
#(
    parameter int TERMINAL = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic done_o
);

    localparam logic [FRAME_CNT_W-1:0] LAST = FRAME_CNT_W'(TERMINAL - 1);

    logic [FRAME_CNT_W-1:0] count_q;
    logic [FRAME_CNT_W-1:0] count_d;

    assign done_o = tick_i && (count_q == LAST);

    // Next count: clear first, wrap on terminal, otherwise count ticks.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (done_o) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_q + 7'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frogger_game_ctrl.sv
// ----------------------------------------------------------------------------
// frogger_game_ctrl
// Game-sequencing controller for Frogger: decides when the frog may move,
// when it respawns, and how score, lives and level evolve.
// Ports:
//   i_Clk    : 25 MHz system clock
//   i_Reset  : synchronous active-high reset
//   bus      : frogger_game_ctrl_if.slave (frame tick, switches, collision,
//              goal in; state, move enable, respawn, score, lives, level,
//              time left out)
// Optional feature: define FROGGER_TIMER_EN to build the per-life time limit
// (o_Time_Left loads TIME_LIMIT_FRAMES on respawn, counts frame ticks in
// PLAY, and reaching zero is a death). Without it o_Time_Left is 0.
// ----------------------------------------------------------------------------
module frogger_game_ctrl
    import frogger_game_ctrl_pkg::*;
#(
    parameter int START_LIVES       = 3,
    parameter int MAX_LEVEL         = 7,
    parameter int DEATH_FRAMES      = 60,
    parameter int LEVELUP_FRAMES    = 90,
    parameter int TIME_LIMIT_FRAMES = 1800
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    frogger_game_ctrl_if.slave   bus
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic                 move_en_q, move_en_d;
    logic                 respawn_q, respawn_d;
    logic                 sw_prev_q;

    logic                 start_evt_s;
    logic                 state_change_s;
    logic                 dying_done_s;
    logic                 lvlup_done_s;
    logic                 timeout_s;
    logic [TIME_W-1:0]    time_left_s;

    // sw_prev_q resets high so a switch held through reset is not an edge.
    assign start_evt_s    = bus.i_Any_Switch & ~sw_prev_q;
    assign state_change_s = (state_d != state_q);

    // Ticks are only offered in the owning state, so a tick that arrives on
    // the entry edge (sampled while still in PLAY) is never counted.
    frogger_game_ctrl_frame_counter #(
        .TERMINAL (DEATH_FRAMES)
    ) u_dying_cnt (
        .clk_i   (i_Clk),
        .rst_i   (i_Reset),
        .clear_i (state_change_s),
        .tick_i  (bus.i_Frame_Tick && (state_q == ST_DYING)),
        .done_o  (dying_done_s)
    );

    frogger_game_ctrl_frame_counter #(
        .TERMINAL (LEVELUP_FRAMES)
    ) u_lvlup_cnt (
        .clk_i   (i_Clk),
        .rst_i   (i_Reset),
        .clear_i (state_change_s),
        .tick_i  (bus.i_Frame_Tick && (state_q == ST_LEVEL_UP)),
        .done_o  (lvlup_done_s)
    );

    // Next-state and next-value logic for the game FSM.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                if (start_evt_s) begin
                    state_d = ST_PLAY;
                    score_d = 7'd0;
                    lives_d = LIVES_INIT;
                    level_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // Death outranks goal; leaving PLAY at once guarantees a
                // single life lost per entry, even with timeout + collision.
                if (bus.i_Collision || timeout_s) begin
                    state_d = ST_DYING;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end else begin
                        lives_d = 2'd0;
                    end
                end else if (bus.i_Frog_At_Goal) begin
                    state_d = ST_LEVEL_UP;
                    score_d = score_sat_inc(score_q);
                    if (level_q >= LEVEL_TOP) begin
                        level_d = LEVEL_TOP;
                    end else begin
                        level_d = level_q + 3'd1;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (dying_done_s) begin
                    if (lives_q == 2'd0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else begin
                    state_d = ST_DYING;
                end
            end
            ST_LEVEL_UP: begin
                if (lvlup_done_s) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_LEVEL_UP;
                end
            end
            ST_GAME_OVER: begin
                if (start_evt_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAME_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        move_en_d = (state_d == ST_PLAY);
        respawn_d = (state_d == ST_PLAY) && (state_q != ST_PLAY);
    end

    // Game FSM and registered status outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            score_q   <= 7'd0;
            lives_q   <= LIVES_INIT;
            level_q   <= 3'd0;
            move_en_q <= 1'b0;
            respawn_q <= 1'b0;
            sw_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            move_en_q <= move_en_d;
            respawn_q <= respawn_d;
            sw_prev_q <= bus.i_Any_Switch;
        end
    end

`ifdef FROGGER_TIMER_EN
    localparam logic [TIME_W-1:0] TIME_LOAD = TIME_W'(TIME_LIMIT_FRAMES);

    logic [TIME_W-1:0] time_left_q, time_left_d;

    // The tick that takes the timer from 1 to 0 is the death event.
    assign timeout_s = (state_q == ST_PLAY) && bus.i_Frame_Tick &&
                       (time_left_q == 11'd1);

    // Reload on every respawn, count down on ticks in PLAY, else hold.
    always_comb begin
        time_left_d = time_left_q;
        if (respawn_d) begin
            time_left_d = TIME_LOAD;
        end else if ((state_q == ST_PLAY) && bus.i_Frame_Tick &&
                     (time_left_q != 11'd0)) begin
            time_left_d = time_left_q - 11'd1;
        end else begin
            time_left_d = time_left_q;
        end
    end

    // Time-left register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            time_left_q <= 11'd0;
        end else begin
            time_left_q <= time_left_d;
        end
    end

    assign time_left_s = time_left_q;
`else
    assign timeout_s   = 1'b0;
    assign time_left_s = 11'd0;
`endif

    assign bus.o_State        = state_q;
    assign bus.o_Move_En      = move_en_q;
    assign bus.o_Frog_Respawn = respawn_q;
    assign bus.o_Score        = score_q;
    assign bus.o_Lives        = lives_q;
    assign bus.o_Level        = level_q;
    assign bus.o_Time_Left    = time_left_s;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_frogger_game_ctrl
// Directed bench for frogger_game_ctrl with DEATH_FRAMES=2,
// LEVELUP_FRAMES=3, START_LIVES=3, MAX_LEVEL=7, TIME_LIMIT_FRAMES=4.
// Timer checks are selected by FROGGER_TIMER_EN.
// ----------------------------------------------------------------------------
module tb_frogger_game_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    frogger_game_ctrl_if bus();

    frogger_game_ctrl #(
        .START_LIVES       (3),
        .MAX_LEVEL         (7),
        .DEATH_FRAMES      (2),
        .LEVELUP_FRAMES    (3),
        .TIME_LIMIT_FRAMES (4)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.i_Frame_Tick = 1'b1;
        step();
        bus.i_Frame_Tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},   32'(bus.o_State),        32'd0);
        chk({tag, "_move"},    32'(bus.o_Move_En),      32'd0);
        chk({tag, "_respawn"}, 32'(bus.o_Frog_Respawn), 32'd0);
        chk({tag, "_score"},   32'(bus.o_Score),        32'd0);
        chk({tag, "_lives"},   32'(bus.o_Lives),        32'd3);
        chk({tag, "_level"},   32'(bus.o_Level),        32'd0);
        chk({tag, "_time"},    32'(bus.o_Time_Left),    32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_Frame_Tick   = 1'b0;
        bus.i_Any_Switch   = 1'b1;
        bus.i_Collision    = 1'b0;
        bus.i_Frog_At_Goal = 1'b0;

        // Reset with the switch held high.
        step(); step(); step();
        chk_reset_vals("rst");
        rst = 1'b0;
        step(); step();
        chk("held_sw_idle", 32'(bus.o_State), 32'd0);
        bus.i_Any_Switch = 1'b0;
        step();
        chk("release_idle", 32'(bus.o_State), 32'd0);
        bus.i_Any_Switch = 1'b1;
        step();
        chk("start_state",   32'(bus.o_State),        32'd1);
        chk("start_respawn", 32'(bus.o_Frog_Respawn), 32'd1);
        chk("start_move",    32'(bus.o_Move_En),      32'd1);
        chk("start_lives",   32'(bus.o_Lives),        32'd3);
        chk("start_score",   32'(bus.o_Score),        32'd0);
        bus.i_Any_Switch = 1'b0;
        step();
        chk("respawn_single", 32'(bus.o_Frog_Respawn), 32'd0);
        chk("play_hold",      32'(bus.o_State),        32'd1);

        // Goal and collision together: death wins.
        bus.i_Frog_At_Goal = 1'b1;
        bus.i_Collision    = 1'b1;
        step();
        bus.i_Frog_At_Goal = 1'b0;
        bus.i_Collision    = 1'b0;
        chk("both_state", 32'(bus.o_State),   32'd2);
        chk("both_lives", 32'(bus.o_Lives),   32'd2);
        chk("both_score", 32'(bus.o_Score),   32'd0);
        chk("dying_move", 32'(bus.o_Move_En), 32'd0);
        tick();
        chk("dying_1tick", 32'(bus.o_State), 32'd2);
        tick();
        chk("dying_exit",    32'(bus.o_State),        32'd1);
        chk("dying_respawn", 32'(bus.o_Frog_Respawn), 32'd1);

        // Goal with a coincident tick that must not count.
        bus.i_Frog_At_Goal = 1'b1;
        bus.i_Frame_Tick   = 1'b1;
        step();
        bus.i_Frog_At_Goal = 1'b0;
        bus.i_Frame_Tick   = 1'b0;
        chk("goal_state", 32'(bus.o_State), 32'd3);
        chk("goal_score", 32'(bus.o_Score), 32'd1);
        chk("goal_level", 32'(bus.o_Level), 32'd1);
        tick(); tick();
        chk("lvlup_2ticks", 32'(bus.o_State), 32'd3);
        tick();
        chk("lvlup_exit",    32'(bus.o_State),        32'd1);
        chk("lvlup_respawn", 32'(bus.o_Frog_Respawn), 32'd1);
        chk("lvlup_score",   32'(bus.o_Score),        32'd1);

        // Remaining two lives lost.
        bus.i_Collision = 1'b1; step(); bus.i_Collision = 1'b0;
        chk("die2_lives", 32'(bus.o_Lives), 32'd1);
        tick(); tick();
        chk("die2_back", 32'(bus.o_State), 32'd1);
        bus.i_Collision = 1'b1; step(); bus.i_Collision = 1'b0;
        chk("die3_lives", 32'(bus.o_Lives), 32'd0);
        tick();
        chk("die3_dying", 32'(bus.o_State), 32'd2);
        tick();
        chk("gameover_state",   32'(bus.o_State),        32'd4);
        chk("gameover_respawn", 32'(bus.o_Frog_Respawn), 32'd0);
        bus.i_Collision = 1'b1; step(); bus.i_Collision = 1'b0;
        chk("gameover_frozen_lives", 32'(bus.o_Lives), 32'd0);
        chk("gameover_frozen_state", 32'(bus.o_State), 32'd4);
        bus.i_Any_Switch = 1'b1; step();
        chk("gameover_to_idle", 32'(bus.o_State), 32'd0);
        chk("idle_score_kept",  32'(bus.o_Score), 32'd1);
        bus.i_Any_Switch = 1'b0; step();
        chk("idle_needs_press", 32'(bus.o_State), 32'd0);
        bus.i_Any_Switch = 1'b1; step();
        bus.i_Any_Switch = 1'b0;
        chk("restart_state", 32'(bus.o_State), 32'd1);
        chk("restart_score", 32'(bus.o_Score), 32'd0);
        chk("restart_lives", 32'(bus.o_Lives), 32'd3);
        chk("restart_level", 32'(bus.o_Level), 32'd0);
        step();

        // Drive score to 99 and level to 7.
        for (int g = 0; g < 99; g++) begin
            bus.i_Frog_At_Goal = 1'b1; step(); bus.i_Frog_At_Goal = 1'b0;
            tick(); tick(); tick();
        end
        chk("sat_state", 32'(bus.o_State), 32'd1);
        chk("sat_score", 32'(bus.o_Score), 32'd99);
        chk("sat_level", 32'(bus.o_Level), 32'd7);
        bus.i_Frog_At_Goal = 1'b1; step(); bus.i_Frog_At_Goal = 1'b0;
        chk("sat_goal_state", 32'(bus.o_State), 32'd3);
        chk("sat_goal_score", 32'(bus.o_Score), 32'd99);
        chk("sat_goal_level", 32'(bus.o_Level), 32'd7);
        tick(); tick(); tick();
        chk("sat_back", 32'(bus.o_State), 32'd1);

`ifdef FROGGER_TIMER_EN
        chk("timer_load", 32'(bus.o_Time_Left), 32'd4);
        tick(); tick(); tick();
        chk("timer_left1", 32'(bus.o_Time_Left), 32'd1);
        chk("timer_play",  32'(bus.o_State),     32'd1);
        bus.i_Collision = 1'b1;
        tick();
        bus.i_Collision = 1'b0;
        chk("timeout_state", 32'(bus.o_State),     32'd2);
        chk("timeout_time",  32'(bus.o_Time_Left), 32'd0);
        chk("timeout_lives", 32'(bus.o_Lives),     32'd2);
        tick();
        chk("timer_hold_dying", 32'(bus.o_Time_Left), 32'd0);
        tick();
        chk("timer_respawn_state", 32'(bus.o_State),        32'd1);
        chk("timer_respawn_pulse", 32'(bus.o_Frog_Respawn), 32'd1);
        chk("timer_reload",        32'(bus.o_Time_Left),    32'd4);
`else
        tick(); tick(); tick(); tick();
        chk("notimer_state", 32'(bus.o_State),     32'd1);
        chk("notimer_time",  32'(bus.o_Time_Left), 32'd0);
        chk("notimer_lives", 32'(bus.o_Lives),     32'd3);
`endif

        // Reset mid-game beats a coincident collision.
        rst = 1'b1;
        bus.i_Collision = 1'b1;
        step();
        chk_reset_vals("midrst");
        rst = 1'b0;
        bus.i_Collision = 1'b0;
        step();
        chk("after_midrst_idle", 32'(bus.o_State), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
